// File: rtl/spi_ram_param_if.sv
// Command/response bundle between the SPI slave front end and spi_ram_param.
// The master side (SPI slave) drives command words; the slave side (RAM) returns
// read data and the status pulses.
interface spi_ram_param_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W+1:0] din;
    logic              rx_valid;
    logic [WORD_W-1:0] dout;
    logic              tx_valid;
    logic              proto_err;
    logic              parity_err;

    modport master (
        output din, rx_valid,
        input  dout, tx_valid, proto_err, parity_err
    );

    modport slave (
        input  din, rx_valid,
        output dout, tx_valid, proto_err, parity_err
    );
endinterface

// File: rtl/spi_ram_param.sv
// spi_ram_param: parametrised single-port RAM driven by the 2-bit SPI command
// protocol (00 write addr, 01 write data, 10 read addr, 11 read data).
// Optional feature macro: RAM_PARITY_EN adds a stored even-parity bit per word
// and reports mismatches on parity_err alongside tx_valid.
// ADDR_W must not exceed WORD_W and MEM_DEPTH must not exceed 2**ADDR_W.
module spi_ram_param #(
    parameter int WORD_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_param_if.slave bus
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = WORD_W + 1;
`else
    localparam int MEM_W = WORD_W;
`endif

    // Widened by one bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic {
        NO_ADDR  = 1'b0,
        ADDR_SET = 1'b1
    } ptr_state_t;

    logic [1:0]        opcode;
    logic [WORD_W-1:0] payload;
    logic [ADDR_W-1:0] cmd_addr;
    logic              addr_ok;

    assign opcode   = bus.din[WORD_W+1:WORD_W];
    assign payload  = bus.din[WORD_W-1:0];
    assign cmd_addr = payload[ADDR_W-1:0];
    assign addr_ok  = ({1'b0, cmd_addr} < DEPTH_C);

    // Index 0 is the write pointer (opcodes 00/01), index 1 the read pointer (10/11).
    logic [1:0]             fire;
    logic [1:0]             reject;
    logic [1:0][ADDR_W-1:0] ptr_all;

    // Both pointers share the same NO_ADDR/ADDR_SET behaviour; only the
    // opcode high bit selecting them differs.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            localparam logic SEL = (gi == 1);

            ptr_state_t        state_q, state_d;
            logic [ADDR_W-1:0] ptr_q, ptr_d;
            logic              addr_cmd, data_cmd;
            logic              fire_c, reject_c;

            assign addr_cmd = bus.rx_valid && (opcode == {SEL, 1'b0});
            assign data_cmd = bus.rx_valid && (opcode == {SEL, 1'b1});

            // Pointer state and address register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= NO_ADDR;
                    ptr_q   <= '0;
                end else begin
                    state_q <= state_d;
                    ptr_q   <= ptr_d;
                end
            end

            // Address load/reject, data-command acceptance and auto-increment.
            always_comb begin
                state_d  = state_q;
                ptr_d    = ptr_q;
                fire_c   = 1'b0;
                reject_c = 1'b0;
                if (addr_cmd) begin
                    if (addr_ok) begin
                        state_d = ADDR_SET;
                        ptr_d   = cmd_addr;
                    end else begin
                        // Rejected address drops the pointer but keeps its value.
                        state_d  = NO_ADDR;
                        reject_c = 1'b1;
                    end
                end else if (data_cmd) begin
                    if (state_q == ADDR_SET) begin
                        fire_c = 1'b1;
                        if (AUTO_INC != 0) begin
                            ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
                        end
                    end else begin
                        reject_c = 1'b1;
                    end
                end
            end

            assign fire[gi]    = fire_c;
            assign reject[gi]  = reject_c;
            assign ptr_all[gi] = ptr_q;
        end
    endgenerate

    logic              wr_fire, rd_fire;
    logic [ADDR_W-1:0] wa, ra;

    assign wr_fire = fire[0];
    assign rd_fire = fire[1];
    assign wa      = ptr_all[0];
    assign ra      = ptr_all[1];

    logic [MEM_W-1:0] mem_q [MEM_DEPTH];
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;

`ifdef RAM_PARITY_EN
    assign wr_word = {^payload, payload};
`else
    assign wr_word = payload;
`endif
    assign rd_word = mem_q[ra];

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wa] <= wr_word;
        end
    end

    logic [WORD_W-1:0] dout_q;
    logic              tx_valid_q;
    logic              proto_err_q;

    // Registered read port and status pulses; dout holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            tx_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            tx_valid_q  <= rd_fire;
            proto_err_q <= |reject;
            if (rd_fire) begin
                dout_q <= rd_word[WORD_W-1:0];
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.proto_err = proto_err_q;

`ifdef RAM_PARITY_EN
    logic parity_err_q;

    // Stored word includes its even-parity bit, so a clean word XORs to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_fire && (^rd_word);
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/spi_ram_param.md
# spi_ram_param

Parametrised single-port RAM behind the SPI slave's 2-bit command protocol: the SPI slave hands it one command word per `rx_valid` pulse and gets read data back on `dout`/`tx_valid`. Compared with the fixed 8-bit/256-word RAM, it adds:
- configurable word width, address width and depth;
- address auto-increment for burst transfers;
- a protocol-error flag;
- optional per-word parity.

## Interface
Parameters:
- `WORD_W`, 8, data payload width; `din` is `WORD_W+2` bits.
- `ADDR_W`, 8, address width; must be ≤ `WORD_W`.
- `MEM_DEPTH`, 256, number of words; must be ≤ 2^`ADDR_W`.
- `AUTO_INC`, 1, 1 = address increments after each data write/read; 0 = address holds.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  `WORD_W+2`  command word; `din[WORD_W+1:WORD_W]` is the opcode, `din[WORD_W-1:0]` is the payload.
- `rx_valid`  in  1  `din` valid this cycle; one command per high cycle.
- `dout`  out  `WORD_W`  read data.
- `tx_valid`  out  1  `dout` valid, one cycle per read command.
- `proto_err`  out  1  one-cycle pulse on a rejected command.
- `parity_err`  out  1  one-cycle pulse with `tx_valid` on a parity mismatch; tied 0 without `RAM_PARITY_EN`.

## Operation
Opcodes are decoded only when `rx_valid`=1. With `rx_valid`=0, `din` is ignored and no state changes.

Internal state: write pointer `wa` with `wa_ok`, and read pointer `ra` with `ra_ok`. Each pointer is a 2-state FSM: NO_ADDR ↔ ADDR_SET.

- **00, write address:**
  - payload[`ADDR_W`-1:0] < `MEM_DEPTH` → `wa` ← payload, `wa_ok` ← 1.
  - Otherwise → `wa_ok` ← 0 and `proto_err` pulses.
- **01, write data:**
  - `wa_ok`=1 → mem[`wa`] ← payload. If `AUTO_INC`, `wa` ← `wa`+1, wrapping `MEM_DEPTH`-1 → 0.
  - `wa_ok`=0 → no write and `proto_err` pulses.
- **10, read address:** same as 00, acting on `ra`/`ra_ok`.
- **11, read data:**
  - `ra_ok`=1 → `dout` ← mem[`ra`] and `tx_valid` pulses. If `AUTO_INC`, `ra` increments with the same wrap.
  - `ra_ok`=0 → `proto_err` pulses, `tx_valid` stays 0 and `dout` holds.

Rules common to all commands:
- Pointers stay in ADDR_SET across any number of data commands. Only reset or an out-of-range address returns a pointer to NO_ADDR.
- Opcodes 00/01/10 never assert `tx_valid` on the following cycle.
- `dout` holds its last read value between reads.

## Timing
- Every command takes effect on the rising edge where `rx_valid`=1.
- `tx_valid`, `dout`, `proto_err` and `parity_err` are registered and assert on the cycle after the command (latency 1).
- Write then read of the same address on consecutive cycles returns the newly written data.
- Back-to-back 11 commands give `tx_valid` high on consecutive cycles, one word per cycle, with consecutive addresses when `AUTO_INC`=1.
- Reset values: `dout`=0, `tx_valid`=0, `proto_err`=0, `parity_err`=0, `wa`=`ra`=0, `wa_ok`=`ra_ok`=0. Memory contents are not reset.
- Reset asserted mid-burst discards any read response not yet presented. All outputs go to 0 immediately (asynchronous reset).
- The first command after `rst_n` deassertion is decoded normally.

## Configuration
`RAM_PARITY_EN`:
- **Defined:**
  - The memory is `WORD_W+1` bits wide; each write stores even parity (XOR of payload) alongside the data.
  - Each read recomputes parity. On mismatch, `parity_err`=1 in the same cycle as `tx_valid`; `dout` still carries the stored data.
- **Undefined:** the memory is `WORD_W` bits wide and `parity_err` is constant 0.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles → `dout`=0, `tx_valid`=0, `proto_err`=0. Then 11 with no read address → `proto_err`=1 for one cycle, `tx_valid`=0.
- **Single write/read (defaults):** 00/0x12, 01/0xA5, 10/0x12, 11 → one cycle after the 11, `dout`=0xA5 and `tx_valid`=1; `tx_valid`=0 on the next cycle.
- **Burst with wrap:** `AUTO_INC`=1, `MEM_DEPTH`=256. Write address 0xFE, then data 0x11, 0x22, 0x33. Read address 0xFE, then three back-to-back 11 → `dout` = 0x11, 0x22, 0x33 on consecutive cycles; the third word sits at address 0x00.
- **Out-of-range address:** `MEM_DEPTH`=200, `ADDR_W`=8. Command 00/0xC8 → `proto_err` pulse. A following 01 → second `proto_err`, and memory is unchanged.
- **Idle input:** `rx_valid`=0 with `din`=11_xxxx for 10 cycles → `tx_valid` stays 0 and no pointer moves.
- **Parity (`RAM_PARITY_EN`):** write 0x0F to address 5, then backdoor-flip stored bit 0 and read address 5 → `dout`=0x0E, `tx_valid`=1, `parity_err`=1. With the macro off, the same sequence gives `parity_err`=0.
